// File: rtl/fifo_drain.sv
`timescale 1ns/1ps
// fifo_drain
// Read-side controller for a synchronous FIFO. Issues reads on the FIFO port,
// absorbs the one-cycle read latency in a 2-entry output buffer and presents
// the words in order on a valid/ready stream. Sustains one word per cycle
// when the FIFO has data and the consumer is ready.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   enable      permission to issue new FIFO reads
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en  FIFO read strobe
//   out_valid   out_data holds a word
//   out_ready   consumer accepts the word this cycle
//   out_data    head word of the output buffer
//   busy        controller is not idle
//   rd_count    words delivered since reset (wraps)
module fifo_drain #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q;

    logic       pop;
    logic       capture;
    logic [2:0] level;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign busy      = (state_q != IDLE);
    assign rd_count  = cnt_q;

    assign pop     = out_valid && out_ready;
    // A read issued last cycle returns data now; it always lands in the buffer.
    assign capture = inflight_q;

    // Buffered plus in-flight words, net of this cycle's pop. Reading only
    // while this is below 2 keeps the buffer from ever overflowing, and the
    // dependence on out_ready is what allows a read every cycle when draining.
    assign level      = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_rd_en = (state_q == ACTIVE) && enable && !fifo_empty &&
                        (level < (3'd2 + {2'b00, pop}));

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({capture, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = fifo_data;
                else               tail_d = fifo_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves and a new word arrives: with one entry the new
                // word becomes the head directly.
                if (occ_q == 2'd1) begin
                    head_d = fifo_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = ACTIVE;
            ACTIVE:  if (!enable) state_d = FLUSH;
            FLUSH: begin
                if (enable)
                    state_d = ACTIVE;
                else if (!inflight_q && (occ_q == 2'd0))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (pop) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
`timescale 1ns/1ps
// Testbench for fifo_drain: behavioural FIFO model feeding the DUT, directed
// scenarios plus a random stream, with a scoreboard checked by a monitor.
module tb_fifo_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, fifo_empty, out_ready, wr_en;
    logic [7:0]  fifo_data, wr_data, out_data, out_data4;
    logic        fifo_rd_en, out_valid, busy, rd_en4, valid4, busy4;
    logic [15:0] rd_count;
    logic [3:0]  rd_count4;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;
    int rd_total = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    fifo_drain #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .rd_count(rd_count)
    );

    fifo_drain #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(rd_en4), .out_valid(valid4),
        .out_ready(out_ready), .out_data(out_data4), .busy(busy4), .rd_count(rd_count4)
    );

    // FIFO model: registered read data, empty flag updated at the edge.
    always @(posedge clk) begin
        if (reset) begin
            fq.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= 8'h00;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops, occupancy bound, no read while empty, hold stability.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            n_pop     = 0;
            prev_hold = 1'b0;
        end else begin
            if (fifo_rd_en) rd_total++;
            check("occ_le_2", 32'(dut.occ_q <= 2'd2), 32'd1);
            if (fifo_empty) check("no_rd_when_empty", 32'(fifo_rd_en), 32'd0);
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got %0h, expected no word", out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("order", 32'(out_data), 32'(e));
                    check("order_cnt4", 32'(out_data4), 32'(e));
                end
                n_pop++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    // Observe n negedges; report first/last index and count of reads and pops.
    task automatic observe(input int n, output int rf, output int rl, output int rn,
                           output int pf, output int pl, output int pn);
        rf = -1; rl = -1; rn = 0; pf = -1; pl = -1; pn = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                if (rf < 0) rf = i;
                rl = i;
                rn++;
            end
            if (out_valid && out_ready) begin
                if (pf < 0) pf = i;
                pl = i;
                pn++;
            end
        end
    endtask

    task automatic drain(input int bound, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < bound) begin
            tick();
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rf, rl, rn, pf, pl, pn, r0, pop_idx, idle_idx, k;
        logic saw_flush;
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        repeat (3) tick();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(rd_count), 32'd0);
        check("rst_count4", 32'(rd_count4), 32'd0);
        reset = 1'b0;
        tick();

        // Preloaded burst, consumer always ready.
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        tick();
        out_ready = 1'b1;
        enable    = 1'b1;
        observe(12, rf, rl, rn, pf, pl, pn);
        check("burst_rd_n", 32'(rn), 32'd4);
        check("burst_rd_consec", 32'(rl - rf), 32'd3);
        check("burst_rd_first", 32'(rf), 32'd1);
        check("burst_pop_n", 32'(pn), 32'd4);
        check("burst_pop_consec", 32'(pl - pf), 32'd3);
        check("burst_latency", 32'(pf), 32'(rf + 2));
        tick();
        check("burst_count", 32'(rd_count), 32'd4);

        // Backpressure: buffer fills to two and holds the head.
        out_ready = 1'b0;
        r0 = rd_total;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        repeat (6) tick();
        check("bp_reads", 32'(rd_total - r0), 32'd2);
        check("bp_occ", 32'(dut.occ_q), 32'd2);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        observe(8, rf, rl, rn, pf, pl, pn);
        check("bp_pop_n", 32'(pn), 32'd4);
        check("bp_pop_first", 32'(pf), 32'd0);
        check("bp_pop_consec", 32'(pl - pf), 32'd3);
        check("bp_count", 32'(rd_count), 32'd8);

        // Random writes and random backpressure.
        for (int sent = 0; sent < 1000; ) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom_range(0, 255));
                exp_q.push_back(wr_data);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en     = 1'b0;
        out_ready = 1'b1;
        drain(600, "rand_drained");
        check("rand_count", 32'(rd_count), 32'd1008);

        // Drop enable the cycle after a read: in-flight word still delivered.
        push_word(8'h5A);
        check("flush_rd_issued", 32'(fifo_rd_en), 32'd1);
        tick();
        enable = 1'b0;
        pop_idx = -1; idle_idx = -1; saw_flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (32'(dut.state_q) == 32'd2) saw_flush = 1'b1;
            if (out_valid && out_ready && pop_idx < 0) pop_idx = i;
            if (!busy && idle_idx < 0) idle_idx = i;
        end
        check("flush_popped", 32'(pop_idx), 32'd1);
        check("flush_saw_flush", 32'(saw_flush), 32'd1);
        check("flush_busy_fall", 32'(idle_idx), 32'(pop_idx + 2));
        check("flush_empty_sb", 32'(exp_q.size()), 32'd0);

        // Reset while a word is buffered and another is in flight.
        tick();
        enable    = 1'b1;
        out_ready = 1'b0;
        push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
        k = 0;
        @(negedge clk);
        while (!(dut.occ_q == 2'd1 && dut.inflight_q) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_setup", 32'(k < 20), 32'd1);
        reset = 1'b1;
        tick();
        check("rstm_valid", 32'(out_valid), 32'd0);
        check("rstm_count", 32'(rd_count), 32'd0);
        check("rstm_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_occ", 32'(dut.occ_q), 32'd0);
        check("rstm_inflight", 32'(dut.inflight_q), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 17 words: the 4-bit counter wraps to 1.
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) push_word(8'(i));
        drain(60, "wrap_drained");
        check("wrap_count16", 32'(rd_count), 32'd17);
        check("wrap_count4", 32'(rd_count4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
